axis_down_checker: RTL and testbench

AXI-Stream sink that receives the down-counting test stream and drives `s_ready`. Each accepted beat is checked against an internally generated down-count reference, and frame boundaries are checked against `s_last`. Frame and error statistics are reported for the Axis_Mux simulation benches, where the block terminates each mux output lane.

---
 rtl/axis_down_pkg.sv | 18 +
 rtl/axis_ready_lfsr.sv | 24 ++
 rtl/axis_down_checker.sv | 135 +++++++++++++
 tb/tb_axis_down_checker.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_down_pkg.sv
// Shared types and constants for the down-count stream checker.
package axis_down_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // Fibonacci taps 8,6,5,4 (1-based), as a mask over lfsr[7:0]
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_value);
        return (value == max_value) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/axis_ready_lfsr.sv
// Pseudo-random ready pattern (~75 % duty) from an 8-bit Fibonacci LFSR.
// Advances one step per cycle while advance is high; ready is a decode of flop outputs.
module axis_ready_lfsr
    import axis_down_pkg::*;
(
    input  logic counter_clk,
    input  logic reset,
    input  logic advance,
    output logic ready
);

    logic [7:0] lfsr;

    always_ff @(posedge counter_clk or posedge reset) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else if (advance) begin
            lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
        end
    end

    assign ready = lfsr[0] | lfsr[1];

endmodule

// File: rtl/axis_down_checker.sv
// AXI-Stream sink checking a down-count stream and frame boundaries; 1-cycle check latency.
// s_ready is constant 1 in RECV, or LFSR-gated when AXIS_DOWN_BACKPRESSURE_EN is defined.
module axis_down_checker
    import axis_down_pkg::*;
#(
    parameter int DataWidth = 32,
    parameter int LenWidth  = 5,
    parameter int CntWidth  = 16
) (
    input  logic                 counter_clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 clear,
    input  logic [DataWidth-1:0] start_value,
    input  logic [LenWidth-1:0]  frame_len,
    input  logic [DataWidth-1:0] s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic                 s_last,
    output logic [CntWidth-1:0]  frame_count,
    output logic [CntWidth-1:0]  err_count,
    output logic                 err_pulse,
    output logic                 err_sticky,
    output logic [DataWidth-1:0] first_bad_data,
    output logic [DataWidth-1:0] first_bad_exp,
    output logic                 busy
);

    localparam logic [CntWidth-1:0] CNT_MAX = '1;

    state_t               state;
    state_t               state_nxt;
    logic [DataWidth-1:0] exp_val;
    logic [LenWidth-1:0]  idx;

    logic xfer;
    logic at_last_idx;
    logic frame_end;
    logic beat_err;

    assign busy        = (state == RECV);
    assign xfer        = s_valid & s_ready;
    assign at_last_idx = (idx == frame_len);
    assign frame_end   = s_last | at_last_idx;
    // Several simultaneous conditions still count as a single errored beat
    assign beat_err    = (s_data != exp_val)
                       | (s_last & (idx < frame_len))
                       | (~s_last & at_last_idx);

`ifdef AXIS_DOWN_BACKPRESSURE_EN
    logic lfsr_ready;

    axis_ready_lfsr u_ready_lfsr (
        .counter_clk (counter_clk),
        .reset       (reset),
        .advance     (busy),
        .ready       (lfsr_ready)
    );

    assign s_ready = busy & lfsr_ready;
`else
    assign s_ready = busy;
`endif

    always_ff @(posedge counter_clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (enable) state_nxt = RECV;
            RECV: if (xfer && frame_end && !enable) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Reference generator: a data mismatch never resyncs exp_val
    always_ff @(posedge counter_clk or posedge reset) begin
        if (reset) begin
            exp_val <= '0;
            idx     <= '0;
        end else if (state == IDLE) begin
            if (enable) begin
                exp_val <= start_value;
                idx     <= '0;
            end
        end else if (xfer) begin
            if (frame_end) begin
                exp_val <= start_value;
                idx     <= '0;
            end else begin
                exp_val <= exp_val - 1'b1;
                idx     <= idx + 1'b1;
            end
        end
    end

    always_ff @(posedge counter_clk or posedge reset) begin
        if (reset) begin
            err_pulse      <= 1'b0;
            frame_count    <= '0;
            err_count      <= '0;
            err_sticky     <= 1'b0;
            first_bad_data <= '0;
            first_bad_exp  <= '0;
        end else begin
            err_pulse <= xfer & beat_err;
            if (clear) begin
                frame_count    <= '0;
                err_count      <= '0;
                err_sticky     <= 1'b0;
                first_bad_data <= '0;
                first_bad_exp  <= '0;
            end else begin
                if (xfer && frame_end) begin
                    frame_count <= CntWidth'(sat_inc(32'(frame_count), 32'(CNT_MAX)));
                end
                if (xfer && beat_err) begin
                    err_count <= CntWidth'(sat_inc(32'(err_count), 32'(CNT_MAX)));
                    if (!err_sticky) begin
                        err_sticky     <= 1'b1;
                        first_bad_data <= s_data;
                        first_bad_exp  <= exp_val;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_down_checker.sv
// Directed bench for axis_down_checker: inputs driven on the falling edge, outputs sampled 1 ns after the rising edge.
module tb_axis_down_checker;

    logic        counter_clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        clear;
    logic [31:0] start_value;
    logic [4:0]  frame_len;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        s_last;
    logic [15:0] frame_count;
    logic [15:0] err_count;
    logic        err_pulse;
    logic        err_sticky;
    logic [31:0] first_bad_data;
    logic [31:0] first_bad_exp;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int stall_cycles = 0;

    always #5 counter_clk = ~counter_clk;

    axis_down_checker #(
        .DataWidth (32),
        .LenWidth  (5),
        .CntWidth  (16)
    ) dut (
        .counter_clk    (counter_clk),
        .reset          (reset),
        .enable         (enable),
        .clear          (clear),
        .start_value    (start_value),
        .frame_len      (frame_len),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_last         (s_last),
        .frame_count    (frame_count),
        .err_count      (err_count),
        .err_pulse      (err_pulse),
        .err_sticky     (err_sticky),
        .first_bad_data (first_bad_data),
        .first_bad_exp  (first_bad_exp),
        .busy           (busy)
    );

    // One beat: present on the falling edge, hold until accepted, return err_pulse seen after the edge
    task automatic beat(input logic [31:0] d, input logic l, output logic ep);
        int n;
        n = 0;
        @(negedge counter_clk);
        s_data  = d;
        s_last  = l;
        s_valid = 1'b1;
        while (!s_ready && n < 100) begin
            @(negedge counter_clk);
            n++;
            stall_cycles++;
        end
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL beat_timeout ready=%0b required=1", s_ready);
        end
        @(posedge counter_clk);
        #1;
        ep      = err_pulse;
        s_valid = 1'b0;
    endtask

    task automatic wait_busy();
        int n;
        n = 0;
        while (busy !== 1'b1 && n < 20) begin
            @(posedge counter_clk);
            #1;
            n++;
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL wait_busy busy=%0b required=1", busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; clear = 1'b0;
        s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        start_value = 32'hFFFF_FFFF; frame_len = 5'd3;
        repeat (3) @(posedge counter_clk);
        @(negedge counter_clk);
        checks++;
        if ({s_ready, busy, err_pulse, err_sticky} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_flags got=%b required=0000", {s_ready, busy, err_pulse, err_sticky});
        end
        checks++;
        if ({frame_count, err_count} !== 32'h0) begin
            errors++;
            $display("FAIL rst_counts got=%h required=0", {frame_count, err_count});
        end
        checks++;
        if ({first_bad_data, first_bad_exp} !== 64'h0) begin
            errors++;
            $display("FAIL rst_captures got=%h required=0", {first_bad_data, first_bad_exp});
        end
        reset = 1'b0;
    endtask

    task automatic test_clean_frames();
        logic ep;
        int   pulses;
        pulses = 0;
        @(negedge counter_clk);
        enable = 1'b1;
        checks++;
        if (s_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_in_idle got=%b required=0", s_ready);
        end
        @(posedge counter_clk);
        #1;
        checks++;
        if ({s_ready, busy} !== 2'b11) begin
            errors++;
            $display("FAIL ready_after_recv got=%b required=11", {s_ready, busy});
        end
        for (int f = 0; f < 3; f++)
            for (int b = 0; b < 4; b++) begin
                beat(32'hFFFF_FFFF - b, b == 3, ep);
                pulses += int'(ep);
            end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL clean_pulses got=%0d required=0", pulses);
        end
        checks++;
        if ({frame_count, err_count, err_sticky} !== {16'd3, 16'd0, 1'b0}) begin
            errors++;
            $display("FAIL clean_stats frames=%0d errs=%0d sticky=%b required=3 0 0",
                     frame_count, err_count, err_sticky);
        end
    endtask

    task automatic test_data_error();
        logic       ep;
        logic [3:0] eps;
        for (int b = 0; b < 4; b++) begin
            beat((b == 1) ? 32'h0000_1234 : 32'hFFFF_FFFF - b, b == 3, ep);
            eps[b] = ep;
        end
        checks++;
        if (eps !== 4'b0010) begin
            errors++;
            $display("FAIL data_err_pulses got=%b required=0010", eps);
        end
        checks++;
        if ({frame_count, err_count, err_sticky} !== {16'd4, 16'd1, 1'b1}) begin
            errors++;
            $display("FAIL data_err_stats frames=%0d errs=%0d sticky=%b required=4 1 1",
                     frame_count, err_count, err_sticky);
        end
        checks++;
        if ({first_bad_data, first_bad_exp} !== {32'h0000_1234, 32'hFFFF_FFFE}) begin
            errors++;
            $display("FAIL data_err_capture got=%h/%h required=00001234/fffffffe",
                     first_bad_data, first_bad_exp);
        end
    endtask

    task automatic test_clear();
        @(negedge counter_clk);
        clear = 1'b1;
        @(posedge counter_clk);
        #1;
        clear = 1'b0;
        checks++;
        if ({frame_count, err_count, err_sticky, first_bad_data, first_bad_exp} !== 97'h0) begin
            errors++;
            $display("FAIL clear_stats frames=%0d errs=%0d sticky=%b cap=%h/%h required=all 0",
                     frame_count, err_count, err_sticky, first_bad_data, first_bad_exp);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL clear_fsm busy=%b required=1", busy);
        end
    endtask

    task automatic test_early_last();
        logic       ep;
        logic [5:0] eps;
        beat(32'hFFFF_FFFF, 1'b0, ep); eps[0] = ep;
        beat(32'hFFFF_FFFE, 1'b1, ep); eps[1] = ep;
        for (int b = 0; b < 4; b++) begin
            beat(32'hFFFF_FFFF - b, b == 3, ep);
            eps[2+b] = ep;
        end
        checks++;
        if (eps !== 6'b000010) begin
            errors++;
            $display("FAIL early_last_pulses got=%b required=000010", eps);
        end
        checks++;
        if ({frame_count, err_count} !== {16'd2, 16'd1}) begin
            errors++;
            $display("FAIL early_last_stats frames=%0d errs=%0d required=2 1", frame_count, err_count);
        end
        checks++;
        if ({first_bad_data, first_bad_exp} !== {32'hFFFF_FFFE, 32'hFFFF_FFFE}) begin
            errors++;
            $display("FAIL early_last_capture got=%h/%h required=fffffffe/fffffffe",
                     first_bad_data, first_bad_exp);
        end
    endtask

    task automatic test_missing_last();
        logic       ep;
        logic [7:0] eps;
        for (int b = 0; b < 4; b++) begin
            beat((b == 3) ? 32'h0 : 32'hFFFF_FFFF - b, 1'b0, ep);
            eps[b] = ep;
        end
        for (int b = 0; b < 4; b++) begin
            beat(32'hFFFF_FFFF - b, b == 3, ep);
            eps[4+b] = ep;
        end
        checks++;
        if (eps !== 8'b0000_1000) begin
            errors++;
            $display("FAIL missing_last_pulses got=%b required=00001000", eps);
        end
        checks++;
        if ({frame_count, err_count} !== {16'd4, 16'd2}) begin
            errors++;
            $display("FAIL missing_last_stats frames=%0d errs=%0d required=4 2", frame_count, err_count);
        end
        checks++;
        if (first_bad_data !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL capture_held got=%h required=fffffffe", first_bad_data);
        end
    endtask

    task automatic test_enable_drop();
        logic ep;
        beat(32'hFFFF_FFFF, 1'b0, ep);
        enable = 1'b0;
        beat(32'hFFFF_FFFE, 1'b0, ep);
        beat(32'hFFFF_FFFD, 1'b0, ep);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL enable_drop_midframe busy=%b required=1", busy);
        end
        beat(32'hFFFF_FFFC, 1'b1, ep);
        checks++;
        if ({s_ready, busy} !== 2'b00) begin
            errors++;
            $display("FAIL enable_drop_idle got=%b required=00", {s_ready, busy});
        end
        checks++;
        if (frame_count !== 16'd5) begin
            errors++;
            $display("FAIL enable_drop_frames got=%0d required=5", frame_count);
        end
    endtask

    task automatic test_wrap();
        logic ep;
        int   pulses;
        pulses = 0;
        start_value = 32'd1;
        frame_len   = 5'd2;
        enable      = 1'b1;
        wait_busy();
        beat(32'd1, 1'b0, ep);         pulses += int'(ep);
        beat(32'd0, 1'b0, ep);         pulses += int'(ep);
        beat(32'hFFFF_FFFF, 1'b1, ep); pulses += int'(ep);
        checks++;
        if ({pulses, frame_count, err_count} !== {32'd0, 16'd6, 16'd2}) begin
            errors++;
            $display("FAIL wrap pulses=%0d frames=%0d errs=%0d required=0 6 2",
                     pulses, frame_count, err_count);
        end
    endtask

    task automatic test_clear_coincide();
        logic ep;
        clear = 1'b1;
        beat(32'd7, 1'b0, ep);
        clear = 1'b0;
        checks++;
        if (ep !== 1'b1) begin
            errors++;
            $display("FAIL coincide_pulse got=%b required=1", ep);
        end
        checks++;
        if ({frame_count, err_count, err_sticky, first_bad_data, first_bad_exp} !== 97'h0) begin
            errors++;
            $display("FAIL coincide_stats frames=%0d errs=%0d sticky=%b cap=%h/%h required=all 0",
                     frame_count, err_count, err_sticky, first_bad_data, first_bad_exp);
        end
        beat(32'd0, 1'b0, ep);
        enable = 1'b0;
        beat(32'hFFFF_FFFF, 1'b1, ep);
        checks++;
        if ({frame_count, err_count, busy} !== {16'd1, 16'd0, 1'b0}) begin
            errors++;
            $display("FAIL coincide_after frames=%0d errs=%0d busy=%b required=1 0 0",
                     frame_count, err_count, busy);
        end
    endtask

    task automatic test_len_zero();
        logic       ep;
        logic [2:0] eps;
        start_value = 32'd5;
        frame_len   = 5'd0;
        enable      = 1'b1;
        wait_busy();
        beat(32'd5, 1'b1, ep); eps[0] = ep;
        beat(32'd5, 1'b1, ep); eps[1] = ep;
        beat(32'd5, 1'b0, ep); eps[2] = ep;
        checks++;
        if (eps !== 3'b100) begin
            errors++;
            $display("FAIL len_zero_pulses got=%b required=100", eps);
        end
        checks++;
        if ({frame_count, err_count, first_bad_data, first_bad_exp} !== {16'd4, 16'd1, 32'd5, 32'd5}) begin
            errors++;
            $display("FAIL len_zero_stats frames=%0d errs=%0d cap=%h/%h required=4 1 5/5",
                     frame_count, err_count, first_bad_data, first_bad_exp);
        end
    endtask

    task automatic test_reset_mid();
        logic ep;
        frame_len = 5'd3;
        beat(32'd5, 1'b0, ep);
        @(negedge counter_clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({s_ready, busy} !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid_ready got=%b required=00", {s_ready, busy});
        end
        checks++;
        if ({frame_count, err_count, err_sticky} !== 33'h0) begin
            errors++;
            $display("FAIL reset_mid_stats frames=%0d errs=%0d sticky=%b required=0 0 0",
                     frame_count, err_count, err_sticky);
        end
        start_value = 32'hFFFF_FFFF;
        frame_len   = 5'd7;
        @(negedge counter_clk);
        reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic ep;
        int   pulses;
        pulses       = 0;
        stall_cycles = 0;
        wait_busy();
        for (int f = 0; f < 125; f++)
            for (int b = 0; b < 8; b++) begin
                beat(32'hFFFF_FFFF - b, b == 7, ep);
                pulses += int'(ep);
            end
        checks++;
        if ({pulses, frame_count, err_count} !== {32'd0, 16'd125, 16'd0}) begin
            errors++;
            $display("FAIL stream_stats pulses=%0d frames=%0d errs=%0d required=0 125 0",
                     pulses, frame_count, err_count);
        end
`ifdef AXIS_DOWN_BACKPRESSURE_EN
        checks++;
        if (stall_cycles == 0) begin
            errors++;
            $display("FAIL stream_backpressure stalls=%0d required=nonzero", stall_cycles);
        end
`else
        checks++;
        if (stall_cycles != 0) begin
            errors++;
            $display("FAIL stream_full_rate stalls=%0d required=0", stall_cycles);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_clean_frames();
        test_data_error();
        test_clear();
        test_early_last();
        test_missing_last();
        test_enable_drop();
        test_wrap();
        test_clear_coincide();
        test_len_zero();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
